// File: rtl/dual_issue_scheduler_pkg.sv
// Shared types and constants for the dual-issue scheduler slice.
package dual_issue_scheduler_pkg;

  // Issue FSM: PAIR issues both slots together, SPLIT has slot 2 still pending
  typedef enum logic {
    PAIR  = 1'b0,
    SPLIT = 1'b1
  } sched_state_e;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO       = 5'd0;
  localparam int       MD_LAT_DEFAULT = 32;

  // True when an instruction with sources rs/rt consumes register r (r0 never creates a hazard)
  function automatic logic reads_reg(input reg_idx_t rs, input reg_idx_t rt, input reg_idx_t r);
    return (r != REG_ZERO) && ((rs == r) || (rt == r));
  endfunction

endpackage

// File: rtl/dual_issue_scheduler_md_busy_counter.sv
// Occupancy counter for the single shared mult/div unit.
module md_busy_counter #(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 6
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  output logic busy
);

  localparam logic [CNT_W-1:0] LAT_VAL = CNT_W'(MD_LAT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Reload on a new mult/div, otherwise count down to zero and hold
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LAT_VAL;
    end else if (count_q != '0) begin
      count_d = count_q - ONE;
    end
  end

  // Counter register, cleared immediately by reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy = (count_q != '0);

  // A second mult/div must never start while the unit is still occupied
  md_start_while_busy : assert property (@(posedge clock) disable iff (!reset_n) !(load && busy));

endmodule

// File: rtl/dual_issue_scheduler.sv
// Issue controller at the FD->DX boundary of the 2-wide pipeline.
module dual_issue_scheduler
  import dual_issue_scheduler_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT,
  parameter int CNT_W  = 6
) (
  input  logic     clock,
  input  logic     reset_n,
  input  logic     fd_valid,
  input  reg_idx_t fd_rs_1,
  input  reg_idx_t fd_rs_2,
  input  reg_idx_t fd_rt_1,
  input  reg_idx_t fd_rt_2,
  input  reg_idx_t fd_rd_1,
  input  reg_idx_t fd_rd_2,
  input  logic     fd_regWrite_1,
  input  logic     fd_regWrite_2,
  input  logic     fd_ctrl_1,
  input  logic     fd_md_1,
  input  logic     fd_md_2,
  input  logic     DX_MemToReg_1,
  input  logic     DX_MemToReg_2,
  input  reg_idx_t DX_rd_1,
  input  reg_idx_t DX_rd_2,
  input  logic     md_start,
  input  reg_idx_t md_rd,
  input  logic     flush,
  output logic     stall_F,
  output logic     issue_1,
  output logic     issue_2,
  output logic     md_busy,
  output logic     split_st
);

  sched_state_e state_q;
  sched_state_e state_d;

  logic lu_1, lu_2, mdb_1, mdb_2, wr_1, conf, haz_1, haz_2;

  md_busy_counter #(
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) u_md_busy_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (md_start),
    .busy    (md_busy)
  );

  assign lu_1 = (DX_MemToReg_1 && reads_reg(fd_rs_1, fd_rt_1, DX_rd_1)) ||
                (DX_MemToReg_2 && reads_reg(fd_rs_1, fd_rt_1, DX_rd_2));
  assign lu_2 = (DX_MemToReg_1 && reads_reg(fd_rs_2, fd_rt_2, DX_rd_1)) ||
                (DX_MemToReg_2 && reads_reg(fd_rs_2, fd_rt_2, DX_rd_2));

  assign mdb_1 = md_busy && (fd_md_1 || reads_reg(fd_rs_1, fd_rt_1, md_rd));
  assign mdb_2 = md_busy && (fd_md_2 || reads_reg(fd_rs_2, fd_rt_2, md_rd));

  assign wr_1 = fd_regWrite_1 && (fd_rd_1 != REG_ZERO);
  assign conf = (wr_1 && ((fd_rd_1 == fd_rs_2) || (fd_rd_1 == fd_rt_2) ||
                          (fd_regWrite_2 && (fd_rd_1 == fd_rd_2)))) ||
                fd_ctrl_1 || (fd_md_1 && fd_md_2);

  assign haz_1 = lu_1 || mdb_1;
  assign haz_2 = lu_2 || mdb_2;

  // Issue decision for this cycle and the FSM's next state
  always_comb begin
    state_d = state_q;
    stall_F = 1'b0;
    issue_1 = 1'b0;
    issue_2 = 1'b0;
    if (flush || !fd_valid) begin
      state_d = PAIR;
    end else if (state_q == PAIR) begin
      if (haz_1) begin
        stall_F = 1'b1;
      end else if (conf || haz_2) begin
        issue_1 = 1'b1;
        stall_F = 1'b1;
        state_d = SPLIT;
      end else begin
        issue_1 = 1'b1;
        issue_2 = 1'b1;
      end
    end else begin
      if (haz_2) begin
        stall_F = 1'b1;
      end else begin
        issue_2 = 1'b1;
        state_d = PAIR;
      end
    end
  end

  // FSM state register, forced back to PAIR by reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PAIR;
    end else begin
      state_q <= state_d;
    end
  end

  assign split_st = (state_q == SPLIT);

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Scoreboard bench for dual_issue_scheduler: directed scenarios plus randomized traffic.
module tb_dual_issue_scheduler;

  localparam int MD_LAT = 4;
  localparam int CNT_W  = 6;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       fd_valid;
  logic [4:0] fd_rs_1, fd_rs_2, fd_rt_1, fd_rt_2, fd_rd_1, fd_rd_2;
  logic       fd_regWrite_1, fd_regWrite_2, fd_ctrl_1, fd_md_1, fd_md_2;
  logic       DX_MemToReg_1, DX_MemToReg_2;
  logic [4:0] DX_rd_1, DX_rd_2, md_rd;
  logic       md_start, flush;
  logic       stall_F, issue_1, issue_2, md_busy, split_st;

  always #5 clock = ~clock;

  dual_issue_scheduler #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .fd_valid(fd_valid),
    .fd_rs_1(fd_rs_1), .fd_rs_2(fd_rs_2), .fd_rt_1(fd_rt_1), .fd_rt_2(fd_rt_2),
    .fd_rd_1(fd_rd_1), .fd_rd_2(fd_rd_2),
    .fd_regWrite_1(fd_regWrite_1), .fd_regWrite_2(fd_regWrite_2),
    .fd_ctrl_1(fd_ctrl_1), .fd_md_1(fd_md_1), .fd_md_2(fd_md_2),
    .DX_MemToReg_1(DX_MemToReg_1), .DX_MemToReg_2(DX_MemToReg_2),
    .DX_rd_1(DX_rd_1), .DX_rd_2(DX_rd_2),
    .md_start(md_start), .md_rd(md_rd), .flush(flush),
    .stall_F(stall_F), .issue_1(issue_1), .issue_2(issue_2),
    .md_busy(md_busy), .split_st(split_st)
  );

  typedef struct {
    logic       valid;
    logic [4:0] rs [2];
    logic [4:0] rt [2];
    logic [4:0] rd [2];
    logic       wr [2];
    logic       md [2];
    logic       ctrl1;
    logic       dx_load [2];
    logic [4:0] dx_rd [2];
    logic       mds;
    logic [4:0] mdrd;
    logic       flush;
  } stim_t;

  typedef struct {
    string      name;
    logic [4:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: cycles of mult/div occupancy left, and whether slot 2 is still owed
  int   busy_left = 0;
  bit   slot2_owed = 0;

  function automatic bit uses(input stim_t s, input int k, input logic [4:0] r);
    return (r != 5'd0) && (s.rs[k] == r || s.rt[k] == r);
  endfunction

  // Can slot k go to DX this cycle, considering DX loads and the mult/div unit
  function automatic bit blocked(input stim_t s, input int k);
    bit b = 0;
    for (int j = 0; j < 2; j++)
      if (s.dx_load[j] && uses(s, k, s.dx_rd[j])) b = 1;
    if (busy_left > 0 && (s.md[k] || uses(s, k, s.mdrd))) b = 1;
    return b;
  endfunction

  function automatic bit pair_conflict(input stim_t s);
    bit dep = s.wr[0] && s.rd[0] != 5'd0 &&
              (s.rd[0] == s.rs[1] || s.rd[0] == s.rt[1] || (s.wr[1] && s.rd[0] == s.rd[1]));
    return dep || s.ctrl1 || (s.md[0] && s.md[1]);
  endfunction

  // Expected {stall_F, issue_1, issue_2, md_busy, split_st} for the current model state
  function automatic logic [4:0] predict(input stim_t s);
    bit st = 0, i1 = 0, i2 = 0;
    if (!s.flush && s.valid) begin
      if (slot2_owed) begin
        if (blocked(s, 1)) st = 1; else i2 = 1;
      end else if (blocked(s, 0)) begin
        st = 1;
      end else if (pair_conflict(s) || blocked(s, 1)) begin
        i1 = 1; st = 1;
      end else begin
        i1 = 1; i2 = 1;
      end
    end
    return {st, i1, i2, busy_left > 0, slot2_owed};
  endfunction

  function automatic void advance(input stim_t s);
    logic [4:0] e = predict(s);
    if (s.flush || !s.valid) slot2_owed = 0;
    else if (e[3] && !e[2]) slot2_owed = 1;
    else if (e[2]) slot2_owed = 0;
    if (s.mds) busy_left = MD_LAT;
    else if (busy_left > 0) busy_left--;
  endfunction

  function automatic stim_t base_pair();
    stim_t s;
    s.valid = 1; s.ctrl1 = 0; s.mds = 0; s.mdrd = 0; s.flush = 0;
    s.rs[0] = 3; s.rt[0] = 4; s.rd[0] = 1; s.rs[1] = 5; s.rt[1] = 6; s.rd[1] = 2;
    s.wr[0] = 1; s.wr[1] = 1; s.md[0] = 0; s.md[1] = 0;
    s.dx_load[0] = 0; s.dx_load[1] = 0; s.dx_rd[0] = 0; s.dx_rd[1] = 0;
    return s;
  endfunction

  task automatic driveInputs(input stim_t s);
    fd_valid = s.valid;
    fd_rs_1 = s.rs[0]; fd_rt_1 = s.rt[0]; fd_rd_1 = s.rd[0];
    fd_rs_2 = s.rs[1]; fd_rt_2 = s.rt[1]; fd_rd_2 = s.rd[1];
    fd_regWrite_1 = s.wr[0]; fd_regWrite_2 = s.wr[1];
    fd_ctrl_1 = s.ctrl1; fd_md_1 = s.md[0]; fd_md_2 = s.md[1];
    DX_MemToReg_1 = s.dx_load[0]; DX_MemToReg_2 = s.dx_load[1];
    DX_rd_1 = s.dx_rd[0]; DX_rd_2 = s.dx_rd[1];
    md_start = s.mds; md_rd = s.mdrd; flush = s.flush;
  endtask

  task automatic checkOutput(input string name, input logic [4:0] act, input logic [4:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got {stall,i1,i2,busy,split}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive after the edge, queue the model's answer, then step the model
  task automatic applyStimulus(input stim_t s, input string name);
    exp_t e;
    @(posedge clock);
    #1;
    driveInputs(s);
    e.name = name;
    e.exp  = predict(s);
    sb.push_back(e);
    advance(s);
  endtask

  // Monitor: compare presented outputs mid-cycle against the oldest queued expectation
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput(e.name, {stall_F, issue_1, issue_2, md_busy, split_st}, e.exp);
    end
  end

  initial begin
    stim_t s;
    s = base_pair();
    s.valid = 0;
    reset_n = 0;
    driveInputs(s);
    #12;
    checkOutput("reset_state", {stall_F, issue_1, issue_2, md_busy, split_st}, predict(s));
    reset_n = 1;

    // Independent pair issues together
    applyStimulus(base_pair(), "indep_pair");

    // Intra-pair RAW: sub r5,r4,r6 after add r4
    s = base_pair(); s.rd[0] = 4; s.rs[0] = 3; s.rt[0] = 6; s.rd[1] = 5; s.rs[1] = 4; s.rt[1] = 6;
    applyStimulus(s, "raw_split_c0");
    applyStimulus(s, "raw_split_c1");

    // Load-use on r7, then same pattern with DX_rd = r0
    s = base_pair(); s.dx_load[0] = 1; s.dx_rd[0] = 7; s.rs[0] = 7;
    applyStimulus(s, "load_use_stall");
    s.dx_rd[0] = 0;
    applyStimulus(s, "load_use_r0");

    // Mult/div occupancy: slot 1 mult waits out the busy window
    s = base_pair(); s.mds = 1;
    applyStimulus(s, "md_start");
    s = base_pair(); s.md[0] = 1;
    for (int i = 0; i < MD_LAT + 1; i++) applyStimulus(s, "md_wait");

    // Flush in SPLIT
    s = base_pair(); s.ctrl1 = 1;
    applyStimulus(s, "ctrl_split");
    s.flush = 1;
    applyStimulus(s, "flush_split");
    applyStimulus(base_pair(), "after_flush");

    // Asynchronous reset while SPLIT and mid-busy
    s = base_pair(); s.mds = 1;
    applyStimulus(s, "md_start2");
    s = base_pair(); s.ctrl1 = 1;
    applyStimulus(s, "split_busy");
    applyStimulus(base_pair(), "split_busy_cnt3");
    #5;
    reset_n = 0;
    busy_left = 0;
    slot2_owed = 0;
    #1;
    checkOutput("async_reset", {stall_F, issue_1, issue_2, md_busy, split_st}, predict(base_pair()));
    @(posedge clock);
    #3;
    reset_n = 1;

    // Randomized traffic over a small register range so hazards are frequent
    for (int n = 0; n < 400; n++) begin
      s.valid = ($urandom_range(0, 9) != 0);
      for (int k = 0; k < 2; k++) begin
        s.rs[k] = 5'($urandom_range(0, 7));
        s.rt[k] = 5'($urandom_range(0, 7));
        s.rd[k] = 5'($urandom_range(0, 7));
        s.wr[k] = ($urandom_range(0, 3) != 0);
        s.md[k] = ($urandom_range(0, 4) == 0);
        s.dx_load[k] = ($urandom_range(0, 2) == 0);
        s.dx_rd[k] = 5'($urandom_range(0, 7));
      end
      s.ctrl1 = ($urandom_range(0, 9) == 0);
      s.flush = ($urandom_range(0, 15) == 0);
      s.mds = (busy_left == 0) && ($urandom_range(0, 7) == 0);
      s.mdrd = 5'($urandom_range(0, 7));
      applyStimulus(s, "random");
    end

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clock);
    if (sb.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
